// File: rtl/mux16_arb_pkg.sv
// Shared constants, state encoding and helpers for the 16-way round-robin arbiter.
// Optional lock input is enabled by defining MUX16_ARB_LOCK_EN.
package mux16_arb_pkg;

    localparam int NREQ  = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [NREQ-1:0] onehot16(input logic [SEL_W-1:0] s);
        logic [NREQ-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux16_rr_arbiter_pick.sv
// Combinational picker: first unmasked request scanning from ptr upward, wrapping.
// Shared by the idle pick and the owner-masked regrant.
module rr_pick16
    import mux16_arb_pkg::*;
(
    input  logic [15:0] req,
    input  logic [3:0]  ptr,
    input  logic [15:0] mask,
    output logic [3:0]  idx,
    output logic        found
);

    logic [15:0] eff;

    assign eff = req & ~mask;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            logic [SEL_W-1:0] c;
            c = ptr + SEL_W'(i);
            if (!found && eff[c]) begin
                idx   = c;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter owning the 16:1 bit mux select, with a bounded hold time.
// Define MUX16_ARB_LOCK_EN to add a lock input that suppresses forced rotation.
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] req,
    input  logic [0:15] w,
`ifdef MUX16_ARB_LOCK_EN
    input  logic        lock,
`endif
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        busy,
    output logic        f
);

    state_e           state_q, state_d;
    logic [15:0]      gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             busy_q, busy_d;

    logic [SEL_W-1:0] pick_ptr, pick_idx;
    logic [15:0]      pick_mask;
    logic             pick_found;
    logic             owner, at_max, lock_en;

`ifdef MUX16_ARB_LOCK_EN
    assign lock_en = lock;
`else
    assign lock_en = 1'b0;
`endif

    // In GRANT the owner is masked and the scan starts just after it
    assign pick_ptr  = (state_q == GRANT) ? sel_q + 4'd1 : ptr_q;
    assign pick_mask = (state_q == GRANT) ? onehot16(sel_q) : '0;
    assign owner     = req[sel_q];
    assign at_max    = (hold_q == CNT_W'(MAX_HOLD - 1));

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = onehot16(pick_idx);
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!owner || (at_max && pick_found && !lock_en)) begin
                    ptr_d  = sel_q + 4'd1;
                    hold_d = '0;
                    if (pick_found) begin
                        gnt_d = onehot16(pick_idx);
                        sel_d = pick_idx;
                    end else begin
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (!at_max) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        f = busy_q & w[sel_q];
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 16:1 single-bit mux datapath among 16 requesters.
- Owns the 4-bit select and drives the winning requester's data bit out through a mux16-style tree.
- Enforces a maximum hold time so that no requester can starve the others.
- Sits between requester logic and the consumer of the muxed bit.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles while others are waiting (legal 1..255).
- CNT_W, 8, width of the hold counter (must hold MAX_HOLD-1).

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous, active-low reset
- req  input  [15:0]  request, bit i = requester i; level-sensitive
- w  input  [0:15]  data bits; w[i] belongs to requester i
- gnt  output  [15:0]  one-hot grant, registered
- sel  output  [3:0]  index of the current or last grant, registered
- busy  output  1  a grant is active (gnt != 0), registered
- f  output  1  muxed bit: w[sel] when busy, else 0 (combinational from w and registers)

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (resetn=0 at a rising edge): gnt=0, sel=0, busy=0, f=0.
  - Internal rotation pointer ptr=0, hold_cnt=0, state=IDLE.
  - Mid-grant reset drops the grant on that edge; pending requests are re-arbitrated from ptr=0.
- Pick function: first i with req[i]=1, scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
- IDLE:
  - If req!=0: gnt<=onehot(pick), sel<=pick, busy<=1, hold_cnt<=0, go to GRANT.
  - Latency: a request sampled at edge N is granted at edge N (visible after that edge).
  - If req==0: stay in IDLE; sel keeps its last value; f=0.
- GRANT, evaluated every edge:
  - Owner released (req[sel]=0):
    - ptr<=sel+1 mod 16 (15 wraps to 0).
    - If other requests are pending, regrant immediately to the pick over req with the owner masked, scanning from sel+1. No idle bubble; hold_cnt<=0.
    - Otherwise gnt<=0, busy<=0, go to IDLE.
  - Owner still requesting and hold_cnt==MAX_HOLD-1 with other requests pending: forced rotation, same as release (owner masked, ptr<=sel+1).
    - The pre-empted owner re-enters arbitration on its turn.
  - Owner still requesting, no other request pending: keep the grant; hold_cnt saturates at MAX_HOLD-1.
  - Otherwise: keep the grant; hold_cnt<=hold_cnt+1.
- MAX_HOLD=1: ownership rotates every cycle whenever others are waiting.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt==onehot(sel) whenever busy=1.
  - A waiting requester is granted within 15*MAX_HOLD+1 cycles.
- f is purely combinational from w and sel, qualified by busy; there is no register on the data path.

Optional Feature:
- Macro MUX16_ARB_LOCK_EN.
- Defined: adds input port lock (1 bit). While lock=1 and req[sel]=1, forced rotation is suppressed and hold_cnt saturates; release on req drop is unchanged. lock is ignored in IDLE.
- Undefined: no lock port; the hold timeout always applies.

Decomposition:
- Shared package mux16_arb_pkg:
  - NREQ=16 and SEL_W=4 constants.
  - State enum {IDLE, GRANT}.
  - Function onehot16(sel).
- Natural sub-module: rr_pick16.
  - Combinational priority-from-pointer picker.
  - Inputs req[15:0], ptr[3:0], mask[15:0]; outputs idx[3:0], found.
  - Used for both the IDLE pick and the masked regrant.
- The data-bit mux may instantiate the existing 16:1 mux with s=sel, qualified by busy.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles with req=16'hFFFF → gnt=0, sel=0, busy=0, f=0. Release reset → gnt=16'h0001, sel=0 next edge.
- Rotation with wrap: req=16'h8001 held, MAX_HOLD=8, ptr=0 → owner 0 for 8 cycles, then 15 for 8 cycles, then 0 again (wrap 15→0). No idle cycle between grants.
- Early release: grant to 3, req=16'h0108, drop req[3] after 2 cycles → gnt=16'h0100, sel=8 on that edge. Drop req[8] → gnt=0, busy=0, IDLE, ptr=9.
- Lone owner saturates: req=16'h0020 for 300 cycles → gnt=16'h0020 throughout. Assert req[2] → grant moves to 2 on the same edge (hold_cnt already saturated).
- Data path: grant to 10 with w[10]=1 and others 0 → f=1. Toggle w[10] → f follows combinationally. After release to IDLE → f=0.
- Mid-grant reset plus lock:
  - Grant to 6, resetn=0 → gnt=0 next edge, ptr=0. Release reset with req=16'h0041 → grant 0 first.
  - With MUX16_ARB_LOCK_EN, lock=1 and req=16'h0041 → owner 0 keeps the grant past 8 cycles. lock=0 → rotate to 6 on the next edge.
